// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bundle: run control, hazard/redirect inputs, imem handshake and IF/ID outputs.
// master = the fetch unit, slave = the pipeline/memory environment driving it.
interface if_fetch_unit_if;
  logic        start_i;
  logic        stall_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic [31:0] PC_o;
  logic [31:0] instruction_o;
  logic        IF_stall_o;
  logic        IF_flush_o;

  modport master (
    input  start_i, stall_i, branch_i, branch_target_i, imem_ack_i, imem_data_i,
    output imem_req_o, imem_addr_o, PC_o, instruction_o, IF_stall_o, IF_flush_o
  );

  modport slave (
    output start_i, stall_i, branch_i, branch_target_i, imem_ack_i, imem_data_i,
    input  imem_req_o, imem_addr_o, PC_o, instruction_o, IF_stall_o, IF_flush_o
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, runs a req/ack fetch per instruction (no prefetch)
// and feeds IF/ID with PC/instruction plus stall/flush, bubbling whenever nothing valid is ready.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input logic            clk,
  input logic            rst_n,
  if_fetch_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, VALID, DRAIN} state_t;

  state_t      state, state_nx;
  logic [31:0] pc_q, pc_nx;
  logic [31:0] addr_q, addr_nx;
  logic [31:0] pc_out_q, pc_out_nx;
  logic [31:0] instr_q, instr_nx;
  logic [31:0] tgt, pc_inc;
  logic        redirect, req, stall, flush;

  assign tgt      = {bus.branch_target_i[31:2], 2'b00};
  assign pc_inc   = pc_q + PC_STEP;
  // Stall always dominates: a branch seen under stall is dropped for that cycle.
  assign redirect = bus.branch_i && !bus.stall_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= '0;
      pc_out_q <= '0;
      instr_q  <= '0;
    end else begin
      state    <= state_nx;
      pc_q     <= pc_nx;
      addr_q   <= addr_nx;
      pc_out_q <= pc_out_nx;
      instr_q  <= instr_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    pc_nx     = pc_q;
    addr_nx   = addr_q;
    pc_out_nx = pc_out_q;
    instr_nx  = instr_q;
    req       = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_i) begin
          addr_nx  = pc_q;
          state_nx = REQ;
        end
      end
      REQ: begin
        req   = 1'b1;
        stall = bus.stall_i;
        flush = !bus.stall_i;
        if (redirect) begin
          pc_nx = tgt;
          // Same-cycle ack belongs to the wrong path: drop it and reissue at the target.
          if (bus.imem_ack_i) addr_nx  = tgt;
          else                state_nx = DRAIN;
        end else if (bus.imem_ack_i) begin
          instr_nx  = bus.imem_data_i;
          pc_out_nx = addr_q;
          state_nx  = VALID;
        end
      end
      VALID: begin
        stall = bus.stall_i;
        flush = redirect;
        if (!bus.stall_i) begin
          state_nx = REQ;
          if (bus.branch_i) begin
            pc_nx   = tgt;
            addr_nx = tgt;
          end else begin
            pc_nx   = pc_inc;
            addr_nx = pc_inc;
          end
        end
      end
      DRAIN: begin
        req   = 1'b1;
        stall = bus.stall_i;
        flush = !bus.stall_i;
        if (redirect) pc_nx = tgt;
        // Stale response retires the old request; the newest redirect target is fetched next.
        if (bus.imem_ack_i) begin
          addr_nx  = redirect ? tgt : pc_q;
          state_nx = REQ;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.imem_req_o    = req;
  assign bus.imem_addr_o   = addr_q;
  assign bus.PC_o          = pc_out_q;
  assign bus.instruction_o = instr_q;
  assign bus.IF_stall_o    = stall;
  assign bus.IF_flush_o    = flush;
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios with constant expectations plus a randomized
// run checked against a flag-based behavioural model of the fetch protocol.
module tb_if_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  if_fetch_unit_if bus ();
  if_fetch_unit_if bus2 ();

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master));
  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(32'd4)) u_wrap (
    .clk(clk), .rst_n(rst_n), .bus(bus2.master));

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
  task automatic set_in(input logic st, input logic sl, input logic br, input logic [31:0] tg,
                        input logic ak, input logic [31:0] dt);
    bus.start_i = st; bus.stall_i = sl; bus.branch_i = br; bus.branch_target_i = tg;
    bus.imem_ack_i = ak; bus.imem_data_i = dt;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus2.start_i = 1'b0; bus2.stall_i = 1'b0; bus2.branch_i = 1'b0;
    bus2.branch_target_i = '0; bus2.imem_ack_i = 1'b0; bus2.imem_data_i = '0;
    set_in(0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  // Reset, start, fetch n words with immediate ack; ends in the request for address 4*n.
  task automatic run_to_req(input int n);
    do_reset();
    set_in(1, 0, 0, 0, 0, 0);
    tick();
    for (int k = 0; k < n; k++) begin
      set_in(0, 0, 0, 0, 1, memf(32'(4 * k)));
      tick();
      set_in(0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_run, m_have, m_stale;
  logic [31:0] m_pc, m_addr, m_pco, m_ins;

  task automatic model_reset();
    m_run = 0; m_have = 0; m_stale = 0;
    m_pc = 32'h0; m_addr = 0; m_pco = 0; m_ins = 0;
  endtask

  task automatic model_step(input logic st, input logic sl, input logic br,
                            input logic [31:0] tg, input logic ak, input logic [31:0] dt);
    logic [31:0] t;
    t = tg & 32'hFFFF_FFFC;
    if (!m_run) begin
      if (st) begin m_run = 1; m_addr = m_pc; end
    end else if (m_have) begin
      if (!sl) begin
        m_pc = br ? t : m_pc + 32'd4;
        m_addr = m_pc;
        m_have = 0;
      end
    end else begin
      if (br && !sl) m_pc = t;
      if (m_stale) begin
        if (ak) begin m_addr = m_pc; m_stale = 0; end
      end else if (br && !sl) begin
        if (ak) m_addr = t; else m_stale = 1;
      end else if (ak) begin
        m_ins = dt; m_pco = m_addr; m_have = 1;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.imem_req_o); end
    checks++; if (bus.imem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus.imem_addr_o); end
    checks++; if (bus.PC_o !== 32'h0 || bus.instruction_o !== 32'h0) begin errors++; $display("FAIL reset_pc_instr: got %h/%h want 0/0", bus.PC_o, bus.instruction_o); end
    checks++; if (bus.IF_stall_o !== 1'b0 || bus.IF_flush_o !== 1'b0) begin errors++; $display("FAIL reset_stall_flush: got %b%b want 00", bus.IF_stall_o, bus.IF_flush_o); end
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    do_reset();
    set_in(1, 0, 0, 0, 0, 0);
    checks++; if (bus.imem_req_o !== 1'b0 || bus.IF_flush_o !== 1'b0) begin errors++; $display("FAIL seq_idle: got req=%b flush=%b want 0 0", bus.imem_req_o, bus.IF_flush_o); end
    tick();
    for (int k = 0; k < 3; k++) begin
      a = 32'(4 * k);
      set_in(0, 0, 0, 0, 1, memf(a));
      checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== a || bus.IF_flush_o !== 1'b1) begin
        errors++; $display("FAIL seq_req%0d: got req=%b addr=%h flush=%b want 1 %h 1", k, bus.imem_req_o, bus.imem_addr_o, bus.IF_flush_o, a); end
      tick();
      set_in(0, 0, 0, 0, 0, 0);
      checks++; if (bus.imem_req_o !== 1'b0 || bus.PC_o !== a || bus.instruction_o !== memf(a) || bus.IF_flush_o !== 1'b0) begin
        errors++; $display("FAIL seq_valid%0d: got req=%b pc=%h ins=%h flush=%b want 0 %h %h 0", k, bus.imem_req_o, bus.PC_o, bus.instruction_o, bus.IF_flush_o, a, memf(a)); end
      tick();
    end
  endtask

  task automatic test_ack_delay();
    run_to_req(1);
    for (int k = 0; k < 3; k++) begin
      set_in(0, 0, 0, 0, 0, 0);
      checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h4 || bus.IF_flush_o !== 1'b1) begin
        errors++; $display("FAIL delay_hold%0d: got req=%b addr=%h flush=%b want 1 4 1", k, bus.imem_req_o, bus.imem_addr_o, bus.IF_flush_o); end
      tick();
    end
    set_in(0, 0, 0, 0, 1, memf(32'h4));
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    checks++; if (bus.PC_o !== 32'h4 || bus.instruction_o !== memf(32'h4)) begin
      errors++; $display("FAIL delay_valid: got pc=%h ins=%h want 4 %h", bus.PC_o, bus.instruction_o, memf(32'h4)); end
  endtask

  task automatic test_stall();
    run_to_req(2);
    set_in(0, 0, 0, 0, 1, memf(32'h8));
    tick();
    for (int k = 0; k < 2; k++) begin
      set_in(0, 1, 0, 0, 1, 32'hDEAD_BEEF);
      checks++; if (bus.IF_stall_o !== 1'b1 || bus.imem_req_o !== 1'b0 || bus.IF_flush_o !== 1'b0 || bus.PC_o !== 32'h8 || bus.instruction_o !== memf(32'h8)) begin
        errors++; $display("FAIL stall_hold%0d: got stall=%b req=%b flush=%b pc=%h want 1 0 0 8", k, bus.IF_stall_o, bus.imem_req_o, bus.IF_flush_o, bus.PC_o); end
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0);
    checks++; if (bus.IF_stall_o !== 1'b0 || bus.PC_o !== 32'h8) begin
      errors++; $display("FAIL stall_release: got stall=%b pc=%h want 0 8", bus.IF_stall_o, bus.PC_o); end
    tick();
    checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'hC) begin
      errors++; $display("FAIL stall_next: got req=%b addr=%h want 1 c", bus.imem_req_o, bus.imem_addr_o); end
  endtask

  task automatic test_branch_drain();
    run_to_req(4);
    set_in(0, 0, 1, 32'h43, 0, 0);
    checks++; if (bus.IF_flush_o !== 1'b1 || bus.imem_addr_o !== 32'h10) begin
      errors++; $display("FAIL drain_br: got flush=%b addr=%h want 1 10", bus.IF_flush_o, bus.imem_addr_o); end
    tick();
    for (int k = 0; k < 2; k++) begin
      set_in(0, 0, 0, 0, 0, 0);
      checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h10 || bus.IF_flush_o !== 1'b1) begin
        errors++; $display("FAIL drain_hold%0d: got req=%b addr=%h flush=%b want 1 10 1", k, bus.imem_req_o, bus.imem_addr_o, bus.IF_flush_o); end
      tick();
    end
    set_in(0, 0, 0, 0, 1, memf(32'h10));
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h40 || bus.IF_flush_o !== 1'b1 || bus.PC_o !== 32'hC || bus.instruction_o !== memf(32'hC)) begin
      errors++; $display("FAIL drain_redirect: got req=%b addr=%h flush=%b pc=%h want 1 40 1 c", bus.imem_req_o, bus.imem_addr_o, bus.IF_flush_o, bus.PC_o); end
    set_in(0, 0, 0, 0, 1, memf(32'h40));
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    checks++; if (bus.PC_o !== 32'h40 || bus.instruction_o !== memf(32'h40)) begin
      errors++; $display("FAIL drain_target: got pc=%h ins=%h want 40 %h", bus.PC_o, bus.instruction_o, memf(32'h40)); end
  endtask

  task automatic test_branch_stall();
    run_to_req(1);
    set_in(0, 0, 0, 0, 1, memf(32'h4));
    tick();
    set_in(0, 1, 1, 32'h80, 0, 0);
    checks++; if (bus.IF_stall_o !== 1'b1 || bus.IF_flush_o !== 1'b0) begin
      errors++; $display("FAIL brstall_out: got stall=%b flush=%b want 1 0", bus.IF_stall_o, bus.IF_flush_o); end
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    checks++; if (bus.PC_o !== 32'h4 || bus.imem_req_o !== 1'b0) begin
      errors++; $display("FAIL brstall_hold: got pc=%h req=%b want 4 0", bus.PC_o, bus.imem_req_o); end
    tick();
    checks++; if (bus.imem_addr_o !== 32'h8) begin
      errors++; $display("FAIL brstall_next: got addr=%h want 8", bus.imem_addr_o); end
  endtask

  task automatic test_branch_ack();
    run_to_req(1);
    set_in(0, 0, 1, 32'h100, 1, memf(32'h4));
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h100 || bus.PC_o !== 32'h0) begin
      errors++; $display("FAIL brack_req: got req=%b addr=%h pc=%h want 1 100 0", bus.imem_req_o, bus.imem_addr_o, bus.PC_o); end
    set_in(0, 0, 0, 0, 1, memf(32'h100));
    tick();
    checks++; if (bus.PC_o !== 32'h100 || bus.instruction_o !== memf(32'h100)) begin
      errors++; $display("FAIL brack_valid: got pc=%h ins=%h want 100 %h", bus.PC_o, bus.instruction_o, memf(32'h100)); end
  endtask

  task automatic test_reset_mid();
    run_to_req(1);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.imem_req_o !== 1'b0 || bus.imem_addr_o !== 32'h0 || bus.PC_o !== 32'h0 || bus.instruction_o !== 32'h0 || bus.IF_flush_o !== 1'b0) begin
      errors++; $display("FAIL rstmid_async: got req=%b addr=%h pc=%h ins=%h flush=%b want all 0", bus.imem_req_o, bus.imem_addr_o, bus.PC_o, bus.instruction_o, bus.IF_flush_o); end
    tick();
    rst_n = 1'b1;
    set_in(0, 1, 0, 0, 1, 32'h1234_5678);
    checks++; if (bus.IF_stall_o !== 1'b0) begin errors++; $display("FAIL rstmid_idle_stall: got %b want 0", bus.IF_stall_o); end
    tick();
    tick();
    checks++; if (bus.imem_req_o !== 1'b0 || bus.PC_o !== 32'h0 || bus.instruction_o !== 32'h0) begin
      errors++; $display("FAIL rstmid_late_ack: got req=%b pc=%h ins=%h want 0 0 0", bus.imem_req_o, bus.PC_o, bus.instruction_o); end
  endtask

  task automatic test_wrap();
    do_reset();
    bus2.start_i = 1'b1;
    tick();
    bus2.start_i = 1'b0; bus2.imem_ack_i = 1'b1; bus2.imem_data_i = 32'hCAFE_0001;
    #1;
    checks++; if (bus2.imem_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first: got %h want fffffffc", bus2.imem_addr_o); end
    tick();
    bus2.imem_ack_i = 1'b0;
    #1;
    checks++; if (bus2.PC_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc: got %h want fffffffc", bus2.PC_o); end
    tick();
    checks++; if (bus2.imem_req_o !== 1'b1 || bus2.imem_addr_o !== 32'h0) begin
      errors++; $display("FAIL wrap_second: got req=%b addr=%h want 1 0", bus2.imem_req_o, bus2.imem_addr_o); end
  endtask

  task automatic test_random();
    logic st, sl, br, ak, e_req, e_flush, e_stall;
    logic [31:0] tg, dt;
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      st = (c == 0) || ($urandom_range(0, 9) == 0);
      sl = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 4) == 0);
      ak = ($urandom_range(0, 2) != 0);
      tg = $urandom;
      dt = $urandom;
      set_in(st, sl, br, tg, ak, dt);
      e_req   = m_run && !m_have;
      e_stall = m_run && sl;
      e_flush = m_run && (m_have ? (br && !sl) : !sl);
      checks++; if (bus.imem_req_o !== e_req || bus.imem_addr_o !== m_addr) begin
        errors++; $display("FAIL rnd_req c%0d: got req=%b addr=%h want %b %h", c, bus.imem_req_o, bus.imem_addr_o, e_req, m_addr); end
      checks++; if (bus.PC_o !== m_pco || bus.instruction_o !== m_ins) begin
        errors++; $display("FAIL rnd_out c%0d: got pc=%h ins=%h want %h %h", c, bus.PC_o, bus.instruction_o, m_pco, m_ins); end
      checks++; if (bus.IF_stall_o !== e_stall || bus.IF_flush_o !== e_flush) begin
        errors++; $display("FAIL rnd_ctl c%0d: got stall=%b flush=%b want %b %b", c, bus.IF_stall_o, bus.IF_flush_o, e_stall, e_flush); end
      model_step(st, sl, br, tg, ak, dt);
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_ack_delay();
    test_stall();
    test_branch_drain();
    test_branch_stall();
    test_branch_ack();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
